// File: rtl/cache_tag_init_ctrl.sv
// cache_tag_init_ctrl
//   Sequencer for the init/flush walk of one cache bank's tag store. After reset it
//   invalidates every line. Afterwards it serves flush requests over a valid/ready
//   handshake. For each flush it drains the bank pipeline, invalidates all lines and
//   then returns a completion response carrying the request tag.
//
// Ports
//   clk              clock
//   reset            asynchronous, active-high reset
//   stall            bank pipeline stall, freezes the walk
//   pipe_empty       bank pipeline and MSHR are empty
//   flush_req_valid  flush request
//   flush_req_tag    request identifier
//   flush_req_ready  flush accepted (only while idle)
//   flush_rsp_valid  flush complete
//   flush_rsp_tag    identifier of the completed flush
//   flush_rsp_ready  response consumed
//   init             tag-store invalidate strobe for the current line
//   init_line_sel    line index being invalidated
//   busy             core requests must not enter the bank
//
// Optional feature (macro CACHE_INIT_PERF_EN)
//   perf_flushes      completed flush handshakes, saturating
//   perf_init_cycles  cycles spent in drain/init/response, saturating
module cache_tag_init_ctrl #(
    parameter int unsigned CACHE_SIZE = 1024,
    parameter int unsigned LINE_SIZE  = 16,
    parameter int unsigned NUM_BANKS  = 1,
    parameter int unsigned NUM_WAYS   = 1,
    parameter int unsigned TAG_WIDTH  = 1,
    localparam int unsigned LINES     = CACHE_SIZE / (LINE_SIZE * NUM_BANKS * NUM_WAYS),
    localparam int unsigned SEL_BITS  = (LINES > 1) ? $clog2(LINES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 pipe_empty,
    input  logic                 flush_req_valid,
    input  logic [TAG_WIDTH-1:0] flush_req_tag,
    output logic                 flush_req_ready,
    output logic                 flush_rsp_valid,
    output logic [TAG_WIDTH-1:0] flush_rsp_tag,
    input  logic                 flush_rsp_ready,
    output logic                 init,
    output logic [SEL_BITS-1:0]  init_line_sel,
    output logic                 busy
`ifdef CACHE_INIT_PERF_EN
    ,
    output logic [31:0]          perf_flushes,
    output logic [31:0]          perf_init_cycles
`endif
);

    // The last line is found by comparison, not by wrap-around, so LINES need not be a
    // power of two.
    localparam logic [SEL_BITS-1:0] LastLine = SEL_BITS'(LINES - 1);

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StDrain,
        StRsp
    } state_e;

    state_e                state_q, state_d;
    logic [SEL_BITS-1:0]   cnt_q, cnt_d;
    logic                  is_flush_q, is_flush_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StInit;
            cnt_q      <= '0;
            is_flush_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_flush_q <= is_flush_d;
            tag_q      <= tag_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        is_flush_d      = is_flush_q;
        tag_d           = tag_q;
        init            = 1'b0;
        flush_req_ready = 1'b0;
        flush_rsp_valid = 1'b0;
        flush_rsp_tag   = '0;
        busy            = 1'b1;

        unique case (state_q)
            StInit: begin
                if (!stall) begin
                    init = 1'b1;
                    if (cnt_q == LastLine) begin
                        cnt_d   = '0;
                        state_d = is_flush_q ? StRsp : StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StIdle: begin
                busy            = 1'b0;
                flush_req_ready = 1'b1;
                if (flush_req_valid) begin
                    tag_d      = flush_req_tag;
                    is_flush_d = 1'b1;
                    state_d    = StDrain;
                end
            end
            StDrain: begin
                if (pipe_empty) begin
                    cnt_d   = '0;
                    state_d = StInit;
                end
            end
            StRsp: begin
                flush_rsp_valid = 1'b1;
                flush_rsp_tag   = tag_q;
                if (flush_rsp_ready) begin
                    is_flush_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase

        // The state already sits in StInit while reset is held; suppress the strobe so
        // no line is written before the walk really starts.
        if (reset) begin
            init = 1'b0;
        end
    end

    assign init_line_sel = cnt_q;

`ifdef CACHE_INIT_PERF_EN
    logic [31:0] perf_flushes_q, perf_init_cycles_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_flushes_q     <= '0;
            perf_init_cycles_q <= '0;
        end else begin
            if (state_q == StRsp && flush_rsp_ready && perf_flushes_q != '1) begin
                perf_flushes_q <= perf_flushes_q + 32'd1;
            end
            if (state_q != StIdle && perf_init_cycles_q != '1) begin
                perf_init_cycles_q <= perf_init_cycles_q + 32'd1;
            end
        end
    end

    assign perf_flushes     = perf_flushes_q;
    assign perf_init_cycles = perf_init_cycles_q;
`endif

endmodule

// File: tb/tb_cache_tag_init_ctrl.sv
module tb_cache_tag_init_ctrl;

    localparam int LINES = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       stall = 1'b0;
    logic       pipe_empty = 1'b1;
    logic       req_valid = 1'b0;
    logic [0:0] req_tag = 1'b0;
    logic       rsp_ready = 1'b0;

    logic       req_ready, rsp_valid, init, busy;
    logic [0:0] rsp_tag;
    logic [5:0] sel;

    // Single-line instance for the LINES=1 boundary.
    logic       req_ready1, rsp_valid1, init1, busy1;
    logic [0:0] rsp_tag1;
    logic [0:0] sel1;

    int checks = 0;
    int errors = 0;

    cache_tag_init_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .pipe_empty      (pipe_empty),
        .flush_req_valid (req_valid),
        .flush_req_tag   (req_tag),
        .flush_req_ready (req_ready),
        .flush_rsp_valid (rsp_valid),
        .flush_rsp_tag   (rsp_tag),
        .flush_rsp_ready (rsp_ready),
        .init            (init),
        .init_line_sel   (sel),
        .busy            (busy)
    );

    cache_tag_init_ctrl #(
        .CACHE_SIZE (16)
    ) dut1 (
        .clk             (clk),
        .reset           (reset),
        .stall           (1'b0),
        .pipe_empty      (1'b1),
        .flush_req_valid (1'b0),
        .flush_req_tag   (1'b0),
        .flush_req_ready (req_ready1),
        .flush_rsp_valid (rsp_valid1),
        .flush_rsp_tag   (rsp_tag1),
        .flush_rsp_ready (1'b0),
        .init            (init1),
        .init_line_sel   (sel1),
        .busy            (busy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: what the bank is doing (walking a line, idle, waiting for the
    // pipeline, or holding a response) and which line the walk is on.
    bit   m_walk, m_idle, m_drain, m_rsp, m_flush;
    int   m_line;
    logic m_tag;
    bit   chk_en = 1'b0;
    int   hits[LINES];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_walk  <= 1'b1;
            m_line  <= 0;
            m_idle  <= 1'b0;
            m_drain <= 1'b0;
            m_rsp   <= 1'b0;
            m_flush <= 1'b0;
            m_tag   <= 1'b0;
        end else if (m_walk) begin
            if (!stall) begin
                if (m_line == LINES - 1) begin
                    m_walk <= 1'b0;
                    m_line <= 0;
                    if (m_flush) m_rsp <= 1'b1;
                    else m_idle <= 1'b1;
                end else begin
                    m_line <= m_line + 1;
                end
            end
        end else if (m_idle) begin
            if (req_valid) begin
                m_idle  <= 1'b0;
                m_drain <= 1'b1;
                m_flush <= 1'b1;
                m_tag   <= req_tag;
            end
        end else if (m_drain) begin
            if (pipe_empty) begin
                m_drain <= 1'b0;
                m_walk  <= 1'b1;
                m_line  <= 0;
            end
        end else if (m_rsp) begin
            if (rsp_ready) begin
                m_rsp   <= 1'b0;
                m_flush <= 1'b0;
                m_idle  <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("init", int'(init), int'(!reset && m_walk && !stall));
            chk("sel", int'(sel), m_walk ? m_line : 0);
            chk("busy", int'(busy), int'(reset || !m_idle));
            chk("req_ready", int'(req_ready), int'(!reset && m_idle));
            chk("rsp_valid", int'(rsp_valid), int'(!reset && m_rsp));
            chk("rsp_tag", int'(rsp_tag), (!reset && m_rsp) ? int'(m_tag) : 0);
            if (reset) begin
                for (int i = 0; i < LINES; i++) hits[i] = 0;
            end else if (init) begin
                hits[sel] = hits[sel] + 1;
            end
        end
    end

    task automatic check_hits(input string name);
        for (int i = 0; i < LINES; i++) begin
            chk(name, hits[i], 1);
            hits[i] = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int left;
        bit armed;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        #1;
        chk("rst_busy", int'(busy), 1);
        chk("rst_init", int'(init), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_sel", int'(sel), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset walk: IDLE on cycle 64; single-line instance idle on cycle 1.
        n = 0;
        while (n < 300) begin
            #1;
            if (n == 0) chk("l1_init", int'(init1), 1);
            if (n == 1) chk("l1_idle", int'(busy1), 0);
            if (!busy) break;
            n++;
            step();
        end
        chk("reset_walk_len", n, 64);
        chk("reset_idle_ready", int'(req_ready), 1);
        check_hits("reset_walk_hits");

        // Flush with empty pipe: response from cycle 66.
        req_valid = 1'b1;
        req_tag   = 1'b1;
        #1;
        chk("accept_ready", int'(req_ready), 1);
        step();
        req_valid = 1'b0;
        req_tag   = 1'b0;
        n = 1;
        while (n < 300) begin
            #1;
            if (rsp_valid) break;
            n++;
            step();
        end
        chk("flush_rsp_latency", n, 66);
        chk("flush_rsp_tag", int'(rsp_tag), 1);
        check_hits("flush_walk_hits");

        // Response back-pressure for 5 cycles.
        repeat (5) begin
            @(posedge clk);
            #2;
            chk("hold_rsp_valid", int'(rsp_valid), 1);
            chk("hold_rsp_tag", int'(rsp_tag), 1);
            chk("hold_busy", int'(busy), 1);
            chk("hold_req_ready", int'(req_ready), 0);
        end

        // Response completes while a new request waits: one bubble, then accept.
        rsp_ready  = 1'b1;
        req_valid  = 1'b1;
        req_tag    = 1'b0;
        pipe_empty = 1'b0;
        step();
        rsp_ready = 1'b0;
        #1;
        chk("bubble_ready", int'(req_ready), 1);
        step();
        req_valid = 1'b0;

        // Pipeline busy for 10 cycles: drain holds, no strobes.
        repeat (10) begin
            #1;
            chk("drain_init", int'(init), 0);
            chk("drain_busy", int'(busy), 1);
            step();
        end
        pipe_empty = 1'b1;

        // Walk with a 3-cycle stall at line 20: 1 drain + 67 walk cycles.
        n = 0;
        left = 0;
        armed = 1'b0;
        while (n < 300) begin
            stall = (left > 0);
            #1;
            if (rsp_valid) break;
            if (stall) begin
                chk("stall_init", int'(init), 0);
                chk("stall_sel", int'(sel), 20);
                left--;
            end else if (!armed && init && sel == 6'd19) begin
                armed = 1'b1;
                left  = 3;
            end
            n++;
            step();
        end
        stall = 1'b0;
        chk("stall_walk_len", n, 68);
        chk("stall_rsp_tag", int'(rsp_tag), 0);
        check_hits("stall_walk_hits");
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Reset during a flush walk at line 30: flush dropped, full walk restarts.
        req_valid = 1'b1;
        req_tag   = 1'b1;
        step();
        req_valid = 1'b0;
        n = 0;
        while (n < 300) begin
            #1;
            if (init && sel == 6'd30) break;
            n++;
            step();
        end
        chk("reach_line30", int'(sel), 30);
        reset = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 1);
        chk("midrst_init", int'(init), 0);
        chk("midrst_sel", int'(sel), 0);
        chk("midrst_rsp_valid", int'(rsp_valid), 0);
        step();
        step();
        reset = 1'b0;
        n = 0;
        seen = 1'b0;
        while (n < 300) begin
            #1;
            if (rsp_valid) seen = 1'b1;
            if (!busy) break;
            n++;
            step();
        end
        chk("rewalk_len", n, 64);
        chk("rewalk_no_rsp", int'(seen), 0);
        chk("rewalk_ready", int'(req_ready), 1);
        check_hits("rewalk_hits");

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_tag_init_ctrl.md
Name: cache_tag_init_ctrl

Overview:
- Sequencer that owns the init/flush walk of a cache bank's tag store.
- Auto-invalidates every line after reset, and serves explicit flush requests through a valid/ready handshake: drain the bank pipeline, invalidate all lines, return a completion response.
- Sits beside the bank pipeline: drives the tag store's init and line-select override, and holds off new core requests while busy.

Parameters:
- CACHE_SIZE, 1024, cache size in bytes.
- LINE_SIZE, 16, line size in bytes.
- NUM_BANKS, 1, number of banks.
- NUM_WAYS, 1, associativity.
- TAG_WIDTH, 1, width of the flush request tag returned with the response; minimum 1.
- Derived localparams:
  - LINES = CACHE_SIZE / (LINE_SIZE * NUM_BANKS * NUM_WAYS); default 64.
  - SEL_BITS = max(1, clog2(LINES)).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  bank pipeline stall; freezes the walk.
- pipe_empty  in  1  bank pipeline and MSHR hold no in-flight requests.
- flush_req_valid  in  1  flush request.
- flush_req_tag  in  TAG_WIDTH  request identifier.
- flush_req_ready  out  1  flush accepted.
- flush_rsp_valid  out  1  flush complete.
- flush_rsp_tag  out  TAG_WIDTH  identifier of the completed flush.
- flush_rsp_ready  in  1  response consumed.
- init  out  1  tag-store invalidate strobe for the current line.
- init_line_sel  out  SEL_BITS  line index being invalidated.
- busy  out  1  core requests must not enter the bank.

Behaviour:
- Reset values: state=INIT, line counter=0, is_flush=0, flush_req_ready=0, flush_rsp_valid=0, flush_rsp_tag=0, busy=1, init=0 while reset is held.
- States and transitions:
  - INIT: walks the lines. On the last line, goes to RSP if is_flush, else IDLE.
  - IDLE: flush_req_ready=1, busy=0. On flush_req_valid, capture the tag, set is_flush=1, go to DRAIN.
  - DRAIN: busy=1. Go to INIT on the first cycle pipe_empty=1, with the counter cleared to 0.
  - RSP: flush_rsp_valid=1, flush_rsp_tag=captured tag, busy=1. When flush_rsp_ready=1, go to IDLE and clear is_flush.
- flush_req_ready is asserted only in IDLE and is combinational from state, not from valid. A request arriving in any other state waits.
- INIT output: init = (state==INIT) && ~stall; init_line_sel = counter.
  - The counter increments only on cycles where init=1.
  - The counter value is 0 in all states except INIT.
- Latencies:
  - Reset walk: exactly LINES unstalled cycles; IDLE is entered on cycle LINES after reset release.
  - Flush with pipe already empty: accept at cycle 0, DRAIN at 1, first init at 2, last init at LINES+1, flush_rsp_valid from LINES+2.
- Each stall cycle extends the walk by one cycle. No line is skipped and no line is written twice with init=1.
- Counter width is SEL_BITS. The last line is detected by counter==LINES-1, not by wrap-around. With LINES=1 the walk takes one cycle.
- busy is 1 in every state except IDLE, so the core sees no acceptance during the walk.
- Reset asserted mid-walk, mid-drain or in RSP:
  - Immediately return to reset values.
  - Any pending flush is dropped and no response is issued.
  - The full walk restarts from line 0.
- Simultaneous flush_rsp_ready and a new flush_req_valid in RSP: the response completes, IDLE is entered, and the new request is accepted on the next cycle (one bubble).

Optional Feature:
- Macro: CACHE_INIT_PERF_EN.
- When defined, adds two outputs:
  - perf_flushes (32 bits): increments on each completed flush handshake in RSP.
  - perf_init_cycles (32 bits): increments every cycle state is DRAIN, INIT or RSP.
- Both counters reset to 0 and saturate at all-ones.
- When undefined, these ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Release reset with stall=0, LINES=64 → init=1 for 64 consecutive cycles with init_line_sel 0..63; busy falls and flush_req_ready rises on cycle 64; no flush_rsp_valid.
- Idle with pipe_empty=1; flush_req_valid=1, tag=1 → accepted in 1 cycle; init lines 0..63 on cycles 2..65; flush_rsp_valid=1 with tag=1 from cycle 66 until rsp_ready.
- pipe_empty=0 for 10 cycles after flush accept → DRAIN held for 10 cycles, no init pulses; walk starts on the cycle after pipe_empty rises.
- stall=1 for 3 cycles while init_line_sel=20 → init=0 and sel=20 held for those cycles; walk resumes at 20; total walk 67 cycles; every line strobed exactly once.
- Hold flush_rsp_ready=0 for 5 cycles → flush_rsp_valid and tag stable, busy=1, flush_req_ready=0 throughout.
- Assert reset at init_line_sel=30 during a flush → no response; after release, a full 0..63 walk, then IDLE.
